serial_deserializer: RTL

SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

---
 rtl/serial_deserializer_pkg.sv | 17 +
 rtl/serial_deserializer.sv | 98 +++++++++
 2 files changed

// File: rtl/serial_deserializer_pkg.sv
// -----------------------------------------------------------------------------
// serial_deserializer_pkg
// Shared constants for the serial-to-parallel deserializer.
//   SD_DATA_WIDTH : default assembled word width
//   CNT_W         : bit counter width for the default word width
//   cnt_w()       : counter width for an arbitrary word width
// -----------------------------------------------------------------------------
package serial_deserializer_pkg;

    localparam int SD_DATA_WIDTH = 32;
    localparam int CNT_W         = $clog2(SD_DATA_WIDTH);

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_deserializer.sv
// -----------------------------------------------------------------------------
// serial_deserializer
// Assembles a serial bit stream into DATA_WIDTH-bit words with a
// valid/ready handshake on both sides.
//   clk        : clock, rising edge
//   reset      : asynchronous active-high reset
//   clear      : synchronous discard of the partial word (output untouched)
//   din        : serial data bit
//   din_valid  : din carries a bit this cycle
//   din_ready  : block accepts din this cycle
//   dout       : assembled word
//   dout_valid : dout holds a complete word
//   dout_ready : downstream takes dout this cycle
//   bit_count  : number of bits held in the partial word
// -----------------------------------------------------------------------------
module serial_deserializer
    import serial_deserializer_pkg::*;
#(
    parameter int DATA_WIDTH = SD_DATA_WIDTH,
    parameter int MSB_FIRST  = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clear,
    input  logic                            din,
    input  logic                            din_valid,
    output logic                            din_ready,
    output logic [DATA_WIDTH-1:0]           dout,
    output logic                            dout_valid,
    input  logic                            dout_ready,
    output logic [$clog2(DATA_WIDTH)-1:0]   bit_count
);

    localparam int              BC_W     = cnt_w(DATA_WIDTH);
    localparam logic [BC_W-1:0] LAST_IDX = BC_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_dout;
    logic [BC_W-1:0]       r_count;
    logic                  r_dout_valid;

    logic                  w_last;
    logic                  w_stall;
    logic                  w_accept;
    logic                  w_complete;
    logic [DATA_WIDTH-1:0] w_shift_nxt;

    // Only the word-completing bit can be blocked: it needs the output
    // register, which is still occupied unless downstream takes it now.
    assign w_last     = (r_count == LAST_IDX);
    assign w_stall    = w_last && r_dout_valid && !dout_ready;
    assign w_accept   = din_valid && !w_stall && !clear;
    assign w_complete = w_accept && w_last;

    // After DATA_WIDTH shifts the first bit has walked to the far end,
    // which is dout[DATA_WIDTH-1] for MSB-first and dout[0] for LSB-first.
    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign w_shift_nxt = {r_shift[DATA_WIDTH-2:0], din};
        end else begin : g_lsb
            assign w_shift_nxt = {din, r_shift[DATA_WIDTH-1:1]};
        end
    endgenerate

    // Partial word and counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (clear) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_shift <= w_shift_nxt;
            r_count <= w_last ? '0 : r_count + BC_W'(1);
        end
    end

    // Output register: a completing word wins over a plain handshake so a
    // take and a load on the same edge leave dout_valid high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else if (w_complete) begin
            r_dout       <= w_shift_nxt;
            r_dout_valid <= 1'b1;
        end else if (r_dout_valid && dout_ready) begin
            r_dout_valid <= 1'b0;
        end
    end

    assign din_ready  = !w_stall;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign bit_count  = r_count;

endmodule
